// File: rtl/alu_ctrl_mdu.sv
// ALU-control decoder for the EX stage with an iterative RV32M multiply/divide unit.
//
// state  | meaning
// IDLE   | waiting for a valid M instruction
// MUL    | radix-2 shift-add, one multiplier bit per cycle
// DIV    | restoring divide, one quotient bit per cycle
// DONE   | result presented for one cycle, pipeline released
module alu_ctrl_mdu #(
  parameter int XLEN     = 32,
  parameter bit EN_M     = 1'b1,
  parameter bit FAST_DIV = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      ALUOp_i,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [3:0]      ALUCtrl_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] mdu_result_o
);

  localparam int CW = $clog2(XLEN);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRL = 4'b1010;
  localparam logic [3:0] ALU_SRA = 4'b1011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic is_m;
  assign is_m = EN_M && (ALUOp_i == 2'b01) && (funct7_i == 7'b0000001);

  // ALU op decode; M instructions leave the ALU on ADD
  always_comb begin
    ALUCtrl_o = ALU_ADD;
    if (!is_m) begin
      case (ALUOp_i)
        2'b01, 2'b10: begin
          case (funct3_i)
            3'b000:  ALUCtrl_o = (ALUOp_i == 2'b01 && funct7_i[5]) ? ALU_SUB : ALU_ADD;
            3'b111:  ALUCtrl_o = ALU_AND;
            3'b110:  ALUCtrl_o = ALU_OR;
            3'b100:  ALUCtrl_o = ALU_XOR;
            3'b010:  ALUCtrl_o = ALU_SLT;
            3'b001:  ALUCtrl_o = ALU_SLL;
            3'b101:  ALUCtrl_o = funct7_i[5] ? ALU_SRA : ALU_SRL;
            default: ALUCtrl_o = ALU_ADD;
          endcase
        end
        2'b00:   ALUCtrl_o = (funct3_i == 3'b000) ? ALU_SUB : ALU_ADD;
        default: ALUCtrl_o = ALU_ADD;
      endcase
    end
  end

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   res_q, res_d;

  // Operand conditioning at accept: magnitudes plus the sign the final result needs
  logic            sgn_a, sgn_b, a_neg, b_neg, b_zero, ovf, neg_in;
  logic [XLEN-1:0] a_mag, b_mag;
  always_comb begin
    sgn_a  = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
             (funct3_i == 3'b100) || (funct3_i == 3'b110);
    sgn_b  = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
    a_neg  = sgn_a && rs1_i[XLEN-1];
    b_neg  = sgn_b && rs2_i[XLEN-1];
    a_mag  = a_neg ? -rs1_i : rs1_i;
    b_mag  = b_neg ? -rs2_i : rs2_i;
    b_zero = (rs2_i == '0);
    ovf    = funct3_i[2] && !funct3_i[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_i);
    if (!funct3_i[2])     neg_in = a_neg ^ b_neg;
    else if (funct3_i[1]) neg_in = a_neg;                    // remainder follows dividend
    else                  neg_in = (a_neg ^ b_neg) && !b_zero; // x/0 quotient stays all-ones
  end

  // One iteration of shift-add multiply and restoring divide on the shared accumulator
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_sh - {1'b0, dvs_q};
    div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  // Final sign fix-up and result selection from the accumulator
  logic [2*XLEN-1:0] acc_sgn;
  logic [XLEN-1:0]   hi_sgn, res_c;
  always_comb begin
    acc_sgn = neg_q ? -acc_q : acc_q;
    hi_sgn  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (!op_q[2]) res_c = (op_q[1:0] == 2'b00) ? acc_sgn[XLEN-1:0] : acc_sgn[2*XLEN-1:XLEN];
    else          res_c = op_q[1] ? hi_sgn : acc_sgn[XLEN-1:0];
  end

  // Sequencer next-state; fast-path divides preload the accumulator with the final answer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    dvs_d   = dvs_q;
    acc_d   = acc_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i && is_m && !flush_i) begin
          op_d  = funct3_i;
          neg_d = neg_in;
          cnt_d = CW'(XLEN-1);
          if (!funct3_i[2]) begin
            state_d = S_MUL;
            dvs_d   = a_mag;
            acc_d   = {{XLEN{1'b0}}, b_mag};
          end else if (FAST_DIV && b_zero) begin
            state_d = S_DONE;
            acc_d   = {a_mag, {XLEN{1'b1}}};
          end else if (FAST_DIV && ovf) begin
            state_d = S_DONE;
            acc_d   = {{XLEN{1'b0}}, a_mag};
          end else begin
            state_d = S_DIV;
            dvs_d   = b_mag;
            acc_d   = {{XLEN{1'b0}}, a_mag};
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        if (!flush_i) res_d = res_c;
      end
    endcase
    if (flush_i && state_q != S_IDLE) state_d = S_IDLE;
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      dvs_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      dvs_q   <= dvs_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign done_o       = (state_q == S_DONE) && !flush_i;
  assign mdu_result_o = done_o ? res_c : res_q;
  assign stall_o      = valid_i && is_m && (state_q != S_DONE);

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Self-checking bench: decode tables, directed M vectors, random M ops against a
// plain-arithmetic reference, and flush/reset corner sequences.
module tb_alu_ctrl_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [1:0]  aluop;
  logic        valid, flush;
  logic [31:0] rs1, rs2;
  logic [3:0]  alu_ctrl;
  logic        stall, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  alu_ctrl_mdu #(.XLEN(32), .EN_M(1'b1), .FAST_DIV(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .funct7_i(funct7), .funct3_i(funct3), .ALUOp_i(aluop),
    .valid_i(valid), .flush_i(flush), .rs1_i(rs1), .rs2_i(rs2),
    .ALUCtrl_o(alu_ctrl), .stall_o(stall), .done_o(done), .mdu_result_o(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] aluop;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] exp;
  } dec_vec_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } m_vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] dec_ref(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
    logic [3:0] tbl [8];
    logic [3:0] code;
    tbl[0] = 4'b0010; tbl[1] = 4'b1001; tbl[2] = 4'b1000; tbl[3] = 4'b0010;
    tbl[4] = 4'b0011; tbl[5] = 4'b1010; tbl[6] = 4'b0001; tbl[7] = 4'b0000;
    if (op == 2'b01 && f7 == 7'h01) return 4'b0010;
    if (op == 2'b00) return (f3 == 3'b000) ? 4'b0110 : 4'b0010;
    if (op == 2'b11) return 4'b0010;
    code = tbl[f3];
    if (f3 == 3'b000 && op == 2'b01 && f7[5]) code = 4'b0110;
    if (f3 == 3'b101 && f7[5]) code = 4'b1011;
    return code;
  endfunction

  function automatic logic [31:0] m_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, sp;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * longint'({32'd0, b}); return sp[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        sp = sa / sb; return sp[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sp = sa % sb; return sp[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // Issue one M op at cycle 0 and follow it until done_o or the cycle budget runs out.
  task automatic run_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit scramble, output logic [31:0] res, output int lat, output bit stall_ok);
    res = '0; lat = -1; stall_ok = 1'b1;
    @(negedge clk);
    valid = 1'b1; flush = 1'b0; aluop = 2'b01; funct7 = 7'h01; funct3 = f3; rs1 = a; rs2 = b;
    for (int k = 0; k <= 60; k++) begin
      #1;
      if (done) begin
        lat = k; res = result;
        if (stall) stall_ok = 1'b0;
        break;
      end
      if (!stall) stall_ok = 1'b0;
      if (scramble && k >= 1) begin
        rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom);
      end
      @(negedge clk);
    end
    valid = 1'b0;
  endtask

  dec_vec_t    dv [20];
  m_vec_t      mv [11];
  logic [31:0] res, prev;
  int          lat, ndone;
  bit          stall_ok;
  logic [2:0]  rf3;
  logic [31:0] ra, rb;

  initial begin
    dv[0]  = '{2'b01, 7'h00, 3'b000, 4'b0010};
    dv[1]  = '{2'b01, 7'h20, 3'b000, 4'b0110};
    dv[2]  = '{2'b01, 7'h00, 3'b111, 4'b0000};
    dv[3]  = '{2'b01, 7'h00, 3'b110, 4'b0001};
    dv[4]  = '{2'b01, 7'h00, 3'b100, 4'b0011};
    dv[5]  = '{2'b01, 7'h00, 3'b010, 4'b1000};
    dv[6]  = '{2'b01, 7'h00, 3'b001, 4'b1001};
    dv[7]  = '{2'b01, 7'h00, 3'b101, 4'b1010};
    dv[8]  = '{2'b01, 7'h20, 3'b101, 4'b1011};
    dv[9]  = '{2'b10, 7'h20, 3'b000, 4'b0010};
    dv[10] = '{2'b10, 7'h20, 3'b101, 4'b1011};
    dv[11] = '{2'b10, 7'h00, 3'b101, 4'b1010};
    dv[12] = '{2'b10, 7'h00, 3'b010, 4'b1000};
    dv[13] = '{2'b00, 7'h55, 3'b000, 4'b0110};
    dv[14] = '{2'b00, 7'h00, 3'b010, 4'b0010};
    dv[15] = '{2'b11, 7'h00, 3'b111, 4'b0010};
    dv[16] = '{2'b01, 7'h01, 3'b111, 4'b0010};
    dv[17] = '{2'b01, 7'h01, 3'b000, 4'b0010};
    dv[18] = '{2'b10, 7'h01, 3'b111, 4'b0000};
    dv[19] = '{2'b01, 7'h03, 3'b111, 4'b0000};

    mv[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    mv[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    mv[2]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
    mv[3]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    mv[4]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};
    mv[5]  = '{3'd5, 32'd100,        32'd0,         32'hFFFF_FFFF, 1};
    mv[6]  = '{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1};
    mv[7]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    mv[8]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    mv[9]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33};
    mv[10] = '{3'd7, 32'd100,        32'd7,         32'd2,         33};

    rst = 1'b1; valid = 1'b0; flush = 1'b0; aluop = 2'b00; funct7 = '0; funct3 = '0;
    rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b0;

    // decode table
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      valid = 1'b0; aluop = dv[i].aluop; funct7 = dv[i].f7; funct3 = dv[i].f3;
      #1;
      chk($sformatf("decode[%0d]", i), 32'(alu_ctrl), 32'(dv[i].exp));
    end

    // random decode
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      valid = 1'b0; aluop = 2'($urandom);
      funct7 = ($urandom_range(0, 3) == 0) ? 7'h01 : 7'($urandom);
      funct3 = 3'($urandom);
      #1;
      chk("decode_rand", 32'(alu_ctrl), 32'(dec_ref(aluop, funct7, funct3)));
    end

    // directed M vectors
    for (int i = 0; i < 11; i++) begin
      run_m(mv[i].f3, mv[i].a, mv[i].b, 1'b1, res, lat, stall_ok);
      chk($sformatf("m_res[%0d]", i), res, mv[i].exp);
      chk($sformatf("m_lat[%0d]", i), 32'(lat), 32'(mv[i].lat));
      chk($sformatf("m_stall[%0d]", i), 32'(stall_ok), 32'd1);
      repeat (2) @(negedge clk);
      #1;
      chk($sformatf("m_hold[%0d]", i), result, mv[i].exp);
    end

    // random M ops against the reference
    for (int i = 0; i < 40; i++) begin
      rf3 = 3'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'd1;
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = rb >> $urandom_range(1, 31);
        default: ;
      endcase
      run_m(rf3, ra, rb, 1'b1, res, lat, stall_ok);
      chk($sformatf("rand_res f3=%0d a=%h b=%h", rf3, ra, rb), res, m_ref(rf3, ra, rb));
      chk("rand_lat", 32'(lat), 32'(lat_ref(rf3, ra, rb)));
      chk("rand_stall", 32'(stall_ok), 32'd1);
    end

    // flush at cycle 10 of a MUL: no done, result keeps its old value
    run_m(3'd0, 32'd11, 32'd13, 1'b0, prev, lat, stall_ok);
    chk("pre_flush_res", prev, 32'd143);
    @(negedge clk);
    valid = 1'b1; aluop = 2'b01; funct7 = 7'h01; funct3 = 3'd0; rs1 = 32'd5; rs2 = 32'd9;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; valid = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (done) ndone++;
      @(negedge clk);
    end
    chk("flush_no_done", 32'(ndone), 32'd0);
    chk("flush_res_hold", result, prev);

    // same-cycle flush and accept: nothing starts
    @(negedge clk);
    valid = 1'b1; flush = 1'b1; funct3 = 3'd4; rs1 = 32'd50; rs2 = 32'd0;
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (done) ndone++;
      @(negedge clk);
    end
    chk("flush_accept_no_done", 32'(ndone), 32'd0);

    // op after a flush runs with full latency
    run_m(3'd5, 32'd1000, 32'd3, 1'b0, res, lat, stall_ok);
    chk("post_flush_res", res, 32'd333);
    chk("post_flush_lat", 32'(lat), 32'd33);

    // reset in the middle of a DIV
    @(negedge clk);
    valid = 1'b1; aluop = 2'b01; funct7 = 7'h01; funct3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd7;
    repeat (5) @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_result", result, 32'd0);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (done) ndone++;
    end
    chk("rst_mid_no_done", 32'(ndone), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
